// File: rtl/usb_nrzi_unstuff_deser.sv
// usb_nrzi_unstuff_deser: NRZI decode, bit unstuffing with violation detection, LSB-first word assembly
module usb_nrzi_unstuff_deser #(
  parameter int DATA_W     = 8,
  parameter int STUFF_LEN  = 6,
  parameter int INIT_LEVEL = 1
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_clr,
  input  logic              i_nrzi,
  input  logic              i_valid,
  output logic [DATA_W-1:0] o_data,
  output logic              o_valid,
  output logic              o_stuffed,
  output logic              o_error
);
  localparam int BW = $clog2(DATA_W);
  logic              prev_level;
  logic [3:0]        ones_cnt;
  logic [BW-1:0]     bit_cnt;
  logic [DATA_W-1:0] sr;
  logic              dec, at_lim, keep, done;
  logic [DATA_W-1:0] word;
  always_comb begin
    dec    = i_nrzi == prev_level;
    at_lim = ones_cnt == 4'(STUFF_LEN);
    keep   = !at_lim;
    done   = keep && bit_cnt == BW'(DATA_W - 1);
    word   = {dec, sr[DATA_W-1:1]};
  end
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      prev_level <= 1'(INIT_LEVEL);
      ones_cnt   <= '0;
      bit_cnt    <= '0;
      sr         <= '0;
      o_data     <= '0;
      o_valid    <= 1'b0;
      o_stuffed  <= 1'b0;
      o_error    <= 1'b0;
    end else begin
      o_valid   <= 1'b0;
      o_stuffed <= 1'b0;
      o_error   <= 1'b0;
      if (i_clr) begin
        prev_level <= 1'(INIT_LEVEL);
        ones_cnt   <= '0;
        bit_cnt    <= '0;
        sr         <= '0;
      end else if (i_valid) begin
        prev_level <= i_nrzi;
        ones_cnt   <= (dec && !at_lim) ? ones_cnt + 4'd1 : 4'd0;
        o_stuffed  <= at_lim && !dec;
        o_error    <= at_lim && dec;
        sr         <= keep ? word : sr;
        bit_cnt    <= (at_lim && dec) || done ? '0 : keep ? bit_cnt + BW'(1) : bit_cnt;
        o_valid    <= done;
        o_data     <= done ? word : o_data;
      end
    end
  end
endmodule

// File: tb/tb_usb_nrzi_unstuff_deser.sv
// tb_usb_nrzi_unstuff_deser: scoreboard bench with directed NRZI vectors
module tb_usb_nrzi_unstuff_deser;
  logic       i_clk = 1'b0;
  logic       i_rst = 1'b1;
  logic       i_clr = 1'b0;
  logic       i_nrzi = 1'b1;
  logic       i_valid = 1'b0;
  logic [7:0] o_data;
  logic       o_valid, o_stuffed, o_error;
  typedef struct {
    int         kind;
    logic [7:0] data;
    int         cyc;
  } exp_t;
  exp_t q[$];
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  logic lvl = 1'b1;
  usb_nrzi_unstuff_deser #(.DATA_W(8), .STUFF_LEN(6), .INIT_LEVEL(1)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_clr(i_clr), .i_nrzi(i_nrzi), .i_valid(i_valid),
    .o_data(o_data), .o_valid(o_valid), .o_stuffed(o_stuffed), .o_error(o_error)
  );
  always #5 i_clk = ~i_clk;
  always @(posedge i_clk) cyc <= cyc + 1;
  always @(negedge i_clk) begin
    exp_t e;
    int   k;
    while (q.size() != 0 && q[0].cyc < cyc) begin
      e = q.pop_front();
      checks++;
      failures++;
      $display("FAIL missed_output kind=%0d expected at cyc=%0d, now cyc=%0d", e.kind, e.cyc, cyc);
    end
    if (!i_rst && (o_valid || o_stuffed || o_error)) begin
      k = o_valid ? 1 : o_stuffed ? 2 : 3;
      checks++;
      if (int'(o_valid) + int'(o_stuffed) + int'(o_error) > 1) begin
        failures++;
        $display("FAIL exclusive v=%b s=%b e=%b required one-hot", o_valid, o_stuffed, o_error);
      end
      checks++;
      if (q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_output kind=%0d data=%h cyc=%0d required none", k, o_data, cyc);
      end else begin
        e = q.pop_front();
        if (k != e.kind || (k == 1 && o_data != e.data) || cyc != e.cyc) begin
          failures++;
          $display("FAIL output kind=%0d data=%h cyc=%0d required kind=%0d data=%h cyc=%0d",
                   k, o_data, cyc, e.kind, e.data, e.cyc);
        end
      end
    end
  end
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge i_clk);
      #1;
    end
  endtask
  task automatic send(input logic b, input int kind, input logic [7:0] data);
    exp_t e;
    i_nrzi = b;
    i_valid = 1'b1;
    @(posedge i_clk);
    #1;
    i_valid = 1'b0;
    lvl = b;
    if (kind != 0) begin
      e.kind = kind;
      e.data = data;
      e.cyc = cyc;
      q.push_back(e);
    end
  endtask
  task automatic send_d(input logic d, input int kind, input logic [7:0] data);
    send(d ? lvl : ~lvl, kind, data);
  endtask
  task automatic send_byte(input logic [7:0] v, input int max_gap);
    for (int i = 0; i < 8; i++) begin
      send_d(v[i], i == 7 ? 1 : 0, v);
      if (i != 7 && max_gap > 0) idle($urandom_range(max_gap, 0));
    end
  endtask
  task automatic clr(input logic with_valid);
    i_clr = 1'b1;
    i_valid = with_valid;
    i_nrzi = 1'b0;
    @(posedge i_clk);
    #1;
    i_clr = 1'b0;
    i_valid = 1'b0;
    lvl = 1'b1;
  endtask
  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask
  initial begin
    idle(3);
    i_rst = 1'b0;
    chk("rst_data", o_data, 8'h00);
    chk("rst_valid", {7'd0, o_valid}, 8'h00);
    chk("rst_stuffed", {7'd0, o_stuffed}, 8'h00);
    chk("rst_error", {7'd0, o_error}, 8'h00);
    for (int i = 0; i < 8; i++) send(i[0], i == 7 ? 1 : 0, 8'h00);
    idle(2);
    clr(1'b0);
    for (int i = 0; i < 6; i++) send(1'b1, 0, 8'h00);
    send(1'b0, 2, 8'h00);
    send(1'b0, 0, 8'h00);
    send(1'b0, 1, 8'hFF);
    idle(2);
    clr(1'b0);
    for (int i = 0; i < 7; i++) send(1'b1, i == 6 ? 3 : 0, 8'h00);
    for (int i = 0; i < 8; i++) send(i[0], i == 7 ? 1 : 0, 8'h00);
    idle(2);
    clr(1'b0);
    send(1'b1, 0, 8'h00);
    send(1'b0, 0, 8'h00);
    send(1'b0, 0, 8'h00);
    send(1'b1, 0, 8'h00);
    send(1'b0, 0, 8'h00);
    idle(1);
    send(1'b0, 0, 8'h00);
    idle(3);
    send(1'b1, 0, 8'h00);
    idle(5);
    send(1'b1, 1, 8'hA5);
    idle(2);
    clr(1'b0);
    send_byte(8'hA5, 5);
    idle(2);
    clr(1'b0);
    send_d(1'b1, 0, 8'h00);
    send_d(1'b0, 0, 8'h00);
    send_d(1'b1, 0, 8'h00);
    send_d(1'b1, 0, 8'h00);
    send_d(1'b0, 0, 8'h00);
    clr(1'b1);
    send_byte(8'h3C, 0);
    idle(2);
    for (int i = 0; i < 5; i++) send_d(i[0], 0, 8'h00);
    i_rst = 1'b1;
    idle(1);
    i_rst = 1'b0;
    lvl = 1'b1;
    chk("midword_rst_data", o_data, 8'h00);
    send_byte(8'h3C, 0);
    idle(2);
    clr(1'b0);
    for (int i = 1; i <= 18; i++)
      send_d(i != 7 && i != 14, i == 7 || i == 14 ? 2 : i == 9 || i == 18 ? 1 : 0, 8'hFF);
    idle(3);
    chk("hold_data_after_clr", o_data, 8'hFF);
    clr(1'b0);
    chk("clr_keeps_data", o_data, 8'hFF);
    idle(3);
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL pending_expectations actual=%0d required=0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
